// File: rtl/fifo_push_arbiter_pkg.sv
// ============================================================================
// Module  : fifo_arb_pkg
// Brief   : Width helpers shared by the FIFO push arbiter files.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int q);
    return $clog2(q + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_push_arbiter_if.sv
// ============================================================================
// Module  : fifo_push_arbiter_if
// Brief   : Producer-side and FIFO-side signals of the push arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_push_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int QUOTA = 4
);
  import fifo_arb_pkg::*;

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = cnt_w(QUOTA);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*WIDTH-1:0]   req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     fifo_push;
  logic [ID_W+WIDTH-1:0]    fifo_write_data;
  logic                     fifo_full;
  logic                     fifo_pop;
  logic [ID_W-1:0]          fifo_read_id;
  logic [N_REQ*CNT_W-1:0]   src_count;
  logic                     err;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_pop, fifo_read_id,
    output req_ready, fifo_push, fifo_write_data, src_count, err
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_pop, fifo_read_id,
    input  req_ready, fifo_push, fifo_write_data, src_count, err
  );

endinterface

`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter; search starts just after the last grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 advance_i,
  output logic [N-1:0]         grant_o,
  output logic [id_w(N)-1:0]   grant_id_o
);

  localparam int ID_W = id_w(N);

  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= ID_W'(N - 1);
    end else if (advance_i) begin
      last_q <= grant_id_o;
    end
  end

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    w_idx      = '0;
    w_found    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_idx = ID_W'((int'(last_q) + k) % N);
      if (!w_found && req_i[w_idx]) begin
        w_found        = 1'b1;
        grant_o[w_idx] = 1'b1;
        grant_id_o     = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
// ============================================================================
// Module  : fifo_push_arbiter
// Brief   : Round-robin sharing of one FIFO push port with per-source quotas.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int QUOTA = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_push_arbiter_if.slave bus
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = cnt_w(QUOTA);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] payload;
  } entry_t;

  logic [N_REQ-1:0] w_eligible;
  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_id;
  logic [N_REQ-1:0] w_underflow;
  logic             w_bad_id;
  logic             w_push;
  entry_t           w_entry;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] count_q [N_REQ];

  // Reset gates the requests so nothing is granted while rst is high.
  assign w_req  = (rst || bus.fifo_full) ? '0 : w_eligible;
  assign w_push = |w_grant;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk        (clk),
    .rst        (rst),
    .req_i      (w_req),
    .advance_i  (w_push),
    .grant_o    (w_grant),
    .grant_id_o (w_grant_id)
  );

  always_comb begin
    w_entry.id      = w_grant_id;
    w_entry.payload = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_entry.payload = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.req_ready       = w_grant;
  assign bus.fifo_push       = w_push;
  assign bus.fifo_write_data = w_entry;

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
      logic             w_inc;
      logic             w_dec;
      logic [CNT_W-1:0] count_d;

      assign w_inc          = w_grant[i];
      assign w_dec          = bus.fifo_pop && (bus.fifo_read_id == ID_W'(i));
      assign w_eligible[i]  = bus.req_valid[i] && (count_q[i] < CNT_W'(QUOTA));
      assign w_underflow[i] = w_dec && !w_inc && (count_q[i] == '0);

      always_comb begin
        count_d = count_q[i];
        if (w_inc && !w_dec) begin
          count_d = count_q[i] + CNT_W'(1);
        end else if (w_dec && !w_inc && (count_q[i] != '0)) begin
          count_d = count_q[i] - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q[i] <= '0;
        end else begin
          count_q[i] <= count_d;
        end
      end

      assign bus.src_count[i*CNT_W +: CNT_W] = count_q[i];
    end
  endgenerate

  // Popping an id that has no live entries, or an id that cannot exist.
  assign w_bad_id = bus.fifo_pop && (int'(bus.fifo_read_id) >= N_REQ);
  assign err_d    = err_q || w_bad_id || (|w_underflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;

endmodule

`default_nettype wire
